reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer for the out-of-order RISC-V core. It allocates one entry per decoded instruction and captures results broadcast on the CDB. It retires entries in program order, one per cycle, driving the register-file commit port (`rob_rf_*`, `rob_head_id`, `rob_tail_id`) and the store-commit handshake to the load/store buffer. It detects branch mispredictions at commit and generates the global flush.

## Interface

**Parameters**
- `XLEN`, 32, data width.
- `ROB_SIZE_WIDTH`, 3, log2 of the entry count (SIZE = 8).
- `REG_CNT_WIDTH`, 5, register index width.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable. When low, all state and outputs hold.
- `stall` in 1: global stall. Allocation is blocked while it is high.
- `dec_ready` in 1: decoder presents an instruction.
- `dec_kind` in 2: 0 = reg-write, 1 = store, 2 = conditional branch, 3 = reserved.
- `dec_rd` in REG_CNT_WIDTH: destination register (kind 0 only).
- `dec_pred_taken` in 1: predictor decision (kind 2).
- `dec_alt_pc` in XLEN: the fetch address *not* taken by the predictor (kind 2).
- `cdb_valid` in 1, `cdb_id` in ROB_SIZE_WIDTH, `cdb_val` in XLEN, `cdb_taken` in 1: result broadcast.
- `qry1_id`, `qry2_id` in ROB_SIZE_WIDTH: operand lookup from the decoder.
- `qry1_ready`, `qry2_ready` out 1; `qry1_val`, `qry2_val` out XLEN: lookup results.
- `rob_full` out 1: all SIZE entries are occupied (combinational from `count`).
- `rob_head_id` out ROB_SIZE_WIDTH: oldest uncommitted slot.
- `rob_tail_id` out ROB_SIZE_WIDTH: slot the current decoder instruction receives.
- `rob_rf_enable` out 1, `rob_rf_rd` out REG_CNT_WIDTH, `rob_rf_val` out XLEN: register commit.
- `rob_store_commit` out 1, `rob_store_id` out ROB_SIZE_WIDTH: store may write memory.
- `flush` out 1, `flush_pc` out XLEN: misprediction recovery.

## Operation

**Entry fields:** `busy`, `done`, `kind`, `rd`, `val`, `pred_taken`, `alt_pc`, `taken`. State also includes `head`, `tail`, and a `count` of ROB_SIZE_WIDTH+1 bits.

**Allocate**
- Occurs when `dec_ready && !stall && !rob_full`.
- Writes the tail entry with `busy=1`, `done=0` and the decoder fields.
- `tail` increments modulo SIZE; it wraps from 7 to 0.

**Writeback**
- `cdb_valid` with `busy[cdb_id]` sets `done`, `val`, and `taken`.
- A writeback to a non-busy slot is ignored.

**Commit**
- Occurs when `busy[head] && done[head]`; `done` is sampled from registered state only.
- Clears `busy[head]` and increments `head` modulo SIZE.
- All commit outputs are registered. In the cycle they are visible, `rob_head_id` already equals the committed id + 1 (mod SIZE); the RF relies on this.
- Kind 0: `rob_rf_enable=1` with `rd` and `val`. `rd`=0 is still driven; the RF discards it.
- Kind 1: `rob_store_commit=1` with `rob_store_id` = committed id.
- Kind 2, `taken == pred_taken`: no side effect.
- Kind 2, mismatch: `flush=1`, `flush_pc=alt_pc`. On the same edge, all `busy` bits clear and `head`, `tail`, `count` reset to 0.
- Kind 3: retires with no side effect.

**Count update**
- +1 on allocate, -1 on commit, unchanged when both occur in the same cycle.

**Flush cycle** (the cycle in which `flush=1`)
- Decoder and CDB inputs are ignored; they belong to the wrong path.
- No allocate, writeback, or commit occurs.

**Queries**
- `qryN_ready = done[id] || (cdb_valid && cdb_id==id)`.
- `qryN_val` takes the CDB value when it matches, otherwise the entry `val`.
- Purely combinational.

**Pulses**
- `rob_rf_enable`, `rob_store_commit`, and `flush` are single-cycle under `rdy=1`.
- Under `rdy=0` they hold until the next `rdy=1` edge, so each is consumed exactly once.

**Reset**
- All `busy` bits clear; `head`, `tail`, `count` = 0.
- Every output register is 0: `rob_rf_*`, `rob_store_*`, `flush`, `flush_pc`.
- `rob_full` = 0.
- Reset has priority over everything and aborts any pending commit or flush.

## Timing

- Allocation at edge E0 → earliest CDB writeback at E1 → commit at E2 → commit outputs visible in cycle E2..E3.
- Commit throughput is one entry per cycle.
- A back-to-back commit is allowed when consecutive entries are already done.
- CDB writeback and a query to the same id in the same cycle: the query sees the CDB value (bypass).
- CDB writeback to `head` in a cycle: commit of that entry happens at the next edge, never the same edge.
- `rob_full` is high when `count == SIZE`; allocation is blocked, but commit proceeds.
- Full with commit and `stall` low: no allocate that cycle. The freed slot becomes available the next cycle.
- `rob_tail_id` is valid combinationally in the cycle the decoder presents the instruction.

## Test plan

- **Reset, then three kind-0 allocations** (rd = 5, 6, 7), CDB writebacks for ids 0, 1, 2 with values 0x11, 0x22, 0x33:
  - Three consecutive `rob_rf_enable` pulses with (5, 0x11), (6, 0x22), (7, 0x33).
  - `rob_head_id` reads 1, 2, 3 during those pulses.
- **Fill 8 entries:**
  - `rob_full=1` and a 9th `dec_ready` is not allocated (`tail` stays 0).
  - Complete id 0 → commit, then `rob_full=0`; the next allocation takes id 0 (wrap).
- **Out-of-order writeback** ids 2, 1, 0:
  - No commit until id 0 is done.
  - Then three commits in order 0, 1, 2 on consecutive cycles.
- **Mispredicted branch:** kind 2 with `pred_taken=0`, `alt_pc=0x1000`, followed by two kind-0 entries; CDB writes `taken=1`.
  - `flush=1`, `flush_pc=0x1000` for one cycle, with no `rob_rf_enable` for the younger entries.
  - After the flush, `head = tail = 0`.
- **Store:** kind 1 at id 3 written back.
  - `rob_store_commit=1`, `rob_store_id=3` for one cycle.
  - `rdy` held low across the pulse: the pulse persists until `rdy` returns, then clears.
- **Query bypass:** `qry1_id=4` while `cdb_id=4`, `cdb_val=0xABCD`.
  - Same cycle: `qry1_ready=1`, `qry1_val=0xABCD`.
  - Next cycle, without CDB: same result from the entry.

Source files
------------

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular reorder buffer for the out-of-order RISC-V core. One entry is
// allocated per decoded instruction at the tail, results are captured from the
// CDB, and entries retire strictly in program order from the head at up to one
// per cycle. A conditional branch whose resolved direction differs from the
// prediction raises a one-cycle global flush at commit time and empties the
// buffer.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable, all state and outputs hold while low
//   stall               blocks allocation
//   dec_*               decoder instruction (ready, kind, rd, prediction, alt pc)
//   cdb_*               common data bus result broadcast
//   qry1_*, qry2_*      combinational operand lookup by ROB id (CDB bypassed)
//   rob_full            all entries occupied
//   rob_head_id         oldest uncommitted slot
//   rob_tail_id         slot the current decoder instruction receives
//   rob_rf_*            registered register-file commit port
//   rob_store_*         registered store-commit handshake to the LSB
//   flush, flush_pc     registered misprediction recovery
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int REG_CNT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      stall,

  input  logic                      dec_ready,
  input  logic [1:0]                dec_kind,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_pred_taken,
  input  logic [XLEN-1:0]           dec_alt_pc,

  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_id,
  input  logic [XLEN-1:0]           cdb_val,
  input  logic                      cdb_taken,

  input  logic [ROB_SIZE_WIDTH-1:0] qry1_id,
  input  logic [ROB_SIZE_WIDTH-1:0] qry2_id,
  output logic                      qry1_ready,
  output logic [XLEN-1:0]           qry1_val,
  output logic                      qry2_ready,
  output logic [XLEN-1:0]           qry2_val,

  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,

  output logic                      rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,

  output logic                      rob_store_commit,
  output logic [ROB_SIZE_WIDTH-1:0] rob_store_id,

  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc
);

  localparam int SIZE = 1 << ROB_SIZE_WIDTH;

  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE    = ROB_SIZE_WIDTH'(1);
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE    = (ROB_SIZE_WIDTH+1)'(1);
  localparam logic [ROB_SIZE_WIDTH:0]   FULL_COUNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_t;

  // Entry storage
  logic                     busy       [SIZE];
  logic                     done       [SIZE];
  kind_t                    kind       [SIZE];
  logic [REG_CNT_WIDTH-1:0] rd         [SIZE];
  logic [XLEN-1:0]          val        [SIZE];
  logic                     pred_taken [SIZE];
  logic [XLEN-1:0]          alt_pc     [SIZE];
  logic                     taken      [SIZE];

  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [ROB_SIZE_WIDTH:0]   count;
  logic [ROB_SIZE_WIDTH:0]   count_next;

  logic  allocate;
  logic  writeback;
  logic  commit;
  logic  mispredict;
  kind_t head_kind;

  logic qry1_hit;
  logic qry2_hit;

  assign rob_full    = (count == FULL_COUNT);
  assign rob_head_id = head;
  assign rob_tail_id = tail;

  // While flush is high the decoder and CDB carry wrong-path traffic, so all
  // three actions are suppressed for that cycle. Commit looks only at the
  // registered done bit, so a CDB result for the head commits one edge later.
  always_comb begin
    head_kind  = kind[head];
    allocate   = dec_ready && !stall && !rob_full && !flush;
    writeback  = cdb_valid && busy[cdb_id] && !flush;
    commit     = busy[head] && done[head] && !flush;
    mispredict = commit && (head_kind == KIND_BRANCH) &&
                 (taken[head] != pred_taken[head]);
  end

  // Occupancy: simultaneous allocate and commit leave the count unchanged.
  always_comb begin
    count_next = count;
    if (allocate && !commit) begin
      count_next = count + CNT_ONE;
    end else if (commit && !allocate) begin
      count_next = count - CNT_ONE;
    end
  end

  // Head, tail and count; a mispredict empties the buffer on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (allocate) begin
          tail <= tail + PTR_ONE;
        end
        if (commit) begin
          head <= head + PTR_ONE;
        end
        count <= count_next;
      end
    end
  end

  // Entry status bits. Done is cleared alongside busy on reset and flush so a
  // stale slot never reports a ready operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
      end
    end else if (rdy) begin
      if (mispredict) begin
        for (int i = 0; i < SIZE; i++) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end
      end else begin
        if (writeback) begin
          done[cdb_id] <= 1'b1;
        end
        if (allocate) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
        end
        if (commit) begin
          busy[head] <= 1'b0;
        end
      end
    end
  end

  // Entry payload; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (allocate) begin
        kind[tail]       <= kind_t'(dec_kind);
        rd[tail]         <= dec_rd;
        pred_taken[tail] <= dec_pred_taken;
        alt_pc[tail]     <= dec_alt_pc;
      end
      if (writeback) begin
        val[cdb_id]   <= cdb_val;
        taken[cdb_id] <= cdb_taken;
      end
    end
  end

  // Registered commit outputs. Pulses are rewritten on every enabled edge, so
  // under rdy=0 they hold and are seen exactly once by the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_rf_enable    <= 1'b0;
      rob_rf_rd        <= '0;
      rob_rf_val       <= '0;
      rob_store_commit <= 1'b0;
      rob_store_id     <= '0;
      flush            <= 1'b0;
      flush_pc         <= '0;
    end else if (rdy) begin
      rob_rf_enable    <= commit && (head_kind == KIND_REG);
      rob_store_commit <= commit && (head_kind == KIND_STORE);
      flush            <= mispredict;
      if (commit && (head_kind == KIND_REG)) begin
        rob_rf_rd  <= rd[head];
        rob_rf_val <= val[head];
      end
      if (commit && (head_kind == KIND_STORE)) begin
        rob_store_id <= head;
      end
      if (mispredict) begin
        flush_pc <= alt_pc[head];
      end
    end
  end

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    qry1_hit   = cdb_valid && (cdb_id == qry1_id);
    qry2_hit   = cdb_valid && (cdb_id == qry2_id);
    qry1_ready = done[qry1_id] || qry1_hit;
    qry2_ready = done[qry2_id] || qry2_hit;
    qry1_val   = qry1_hit ? cdb_val : val[qry1_id];
    qry2_val   = qry2_hit ? cdb_val : val[qry2_id];
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer. A queue-based model of the in-flight
// instruction window predicts every output; a negedge process compares the DUT
// against it each cycle, and the directed sequences add literal expectations
// for the key scenarios (in-order retire, full/wrap, out-of-order writeback,
// mispredict flush, store handshake under rdy=0, query bypass).
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall;
  logic        dec_ready;
  logic [1:0]  dec_kind;
  logic [4:0]  dec_rd;
  logic        dec_pred_taken;
  logic [31:0] dec_alt_pc;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic [2:0]  qry1_id;
  logic [2:0]  qry2_id;
  logic        qry1_ready;
  logic [31:0] qry1_val;
  logic        qry2_ready;
  logic [31:0] qry2_val;
  logic        rob_full;
  logic [2:0]  rob_head_id;
  logic [2:0]  rob_tail_id;
  logic        rob_rf_enable;
  logic [4:0]  rob_rf_rd;
  logic [31:0] rob_rf_val;
  logic        rob_store_commit;
  logic [2:0]  rob_store_id;
  logic        flush;
  logic [31:0] flush_pc;

  reorder_buffer #(.XLEN(32), .ROB_SIZE_WIDTH(3), .REG_CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd),
    .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
    .qry1_id(qry1_id), .qry2_id(qry2_id),
    .qry1_ready(qry1_ready), .qry1_val(qry1_val),
    .qry2_ready(qry2_ready), .qry2_val(qry2_val),
    .rob_full(rob_full), .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
    .rob_rf_enable(rob_rf_enable), .rob_rf_rd(rob_rf_rd), .rob_rf_val(rob_rf_val),
    .rob_store_commit(rob_store_commit), .rob_store_id(rob_store_id),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Model: program-ordered window of in-flight instructions
  typedef struct {
    int          id;
    int          kind;
    logic [31:0] rd;
    bit          pred;
    logic [31:0] alt;
    bit          done;
    logic [31:0] val;
    bit          taken;
  } ent_t;

  ent_t        q[$];
  ent_t        c;
  ent_t        n;
  int          m_head;
  int          m_tail;
  bit          e_rf_en;
  logic [31:0] e_rf_rd;
  logic [31:0] e_rf_val;
  bit          e_st;
  logic [31:0] e_st_id;
  bit          e_flush;
  logic [31:0] e_flush_pc;
  bit          was_flush;
  bit          full_before;
  bit          mis;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_head = 0; m_tail = 0;
      e_rf_en = 0; e_rf_rd = 0; e_rf_val = 0;
      e_st = 0; e_st_id = 0; e_flush = 0; e_flush_pc = 0;
    end else if (rdy) begin
      was_flush   = e_flush;
      full_before = (q.size() == 8);
      mis         = 0;
      e_rf_en = 0; e_st = 0; e_flush = 0;
      if (!was_flush) begin
        if (q.size() > 0 && q[0].done) begin
          c = q.pop_front();
          m_head = (m_head + 1) % 8;
          if (c.kind == 0) begin
            e_rf_en = 1; e_rf_rd = c.rd; e_rf_val = c.val;
          end else if (c.kind == 1) begin
            e_st = 1; e_st_id = 32'(c.id);
          end else if (c.kind == 2 && c.taken != c.pred) begin
            mis = 1;
          end
        end
        if (mis) begin
          e_flush = 1; e_flush_pc = c.alt;
          q.delete();
          m_head = 0; m_tail = 0;
        end else begin
          if (cdb_valid) begin
            foreach (q[i]) begin
              if (q[i].id == int'(cdb_id)) begin
                q[i].done = 1; q[i].val = cdb_val; q[i].taken = cdb_taken;
              end
            end
          end
          if (dec_ready && !stall && !full_before) begin
            n.id = m_tail; n.kind = int'(dec_kind); n.rd = 32'(dec_rd);
            n.pred = dec_pred_taken; n.alt = dec_alt_pc;
            n.done = 0; n.val = 0; n.taken = 0;
            q.push_back(n);
            m_tail = (m_tail + 1) % 8;
          end
        end
      end
    end
  end

  // Query expectation from the model; unknown only for idle slots without a hit.
  task automatic checkQuery(input string name, input logic [2:0] id,
                            input logic act_ready, input logic [31:0] act_val);
    bit          hit  = cdb_valid && (cdb_id == id);
    bit          live = 0;
    bit          d    = 0;
    logic [31:0] v    = 0;
    foreach (q[i]) begin
      if (q[i].id == int'(id)) begin
        live = 1; d = q[i].done; v = q[i].val;
      end
    end
    if (hit) begin
      d = 1; v = cdb_val;
    end
    if (live || hit) begin
      checkOutput({name, "_ready"}, 32'(act_ready), 32'(d));
      if (d) checkOutput({name, "_val"}, act_val, v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("rob_full", 32'(rob_full), 32'(q.size() == 8));
      checkOutput("head_id", 32'(rob_head_id), 32'(m_head));
      checkOutput("tail_id", 32'(rob_tail_id), 32'(m_tail));
      checkOutput("rf_enable", 32'(rob_rf_enable), 32'(e_rf_en));
      if (e_rf_en) begin
        checkOutput("rf_rd", 32'(rob_rf_rd), e_rf_rd);
        checkOutput("rf_val", rob_rf_val, e_rf_val);
      end
      checkOutput("store_commit", 32'(rob_store_commit), 32'(e_st));
      if (e_st) checkOutput("store_id", 32'(rob_store_id), e_st_id);
      checkOutput("flush", 32'(flush), 32'(e_flush));
      if (e_flush) checkOutput("flush_pc", flush_pc, e_flush_pc);
      checkQuery("qry1", qry1_id, qry1_ready, qry1_val);
      checkQuery("qry2", qry2_id, qry2_ready, qry2_val);
    end
  end

  task automatic applyStimulus(input bit dr, input logic [1:0] k, input logic [4:0] r,
                               input bit p, input logic [31:0] a, input bit cv,
                               input logic [2:0] ci, input logic [31:0] cval, input bit ct);
    dec_ready = dr; dec_kind = k; dec_rd = r; dec_pred_taken = p; dec_alt_pc = a;
    cdb_valid = cv; cdb_id = ci; cdb_val = cval; cdb_taken = ct;
  endtask

  task automatic idle();
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 0, 3'd0, 32'd0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; qry1_id = 3'd0; qry2_id = 3'd0;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_head", 32'(rob_head_id), 32'd0);
    checkOutput("reset_tail", 32'(rob_tail_id), 32'd0);
    checkOutput("reset_full", 32'(rob_full), 32'd0);
    checkOutput("reset_rf_en", 32'(rob_rf_enable), 32'd0);
    checkOutput("reset_flush", 32'(flush), 32'd0);
    checkOutput("reset_flush_pc", flush_pc, 32'd0);
    checkOutput("reset_store", 32'(rob_store_commit), 32'd0);

    // In-order retire of three register writes
    applyStimulus(1, 2'd0, 5'd5, 0, 32'd0, 0, 3'd0, 32'h00, 0); tick();
    applyStimulus(1, 2'd0, 5'd6, 0, 32'd0, 1, 3'd0, 32'h11, 0); tick();
    applyStimulus(1, 2'd0, 5'd7, 0, 32'd0, 1, 3'd1, 32'h22, 0); tick();
    checkOutput("t1_en0", 32'(rob_rf_enable), 32'd1);
    checkOutput("t1_rd0", 32'(rob_rf_rd), 32'd5);
    checkOutput("t1_val0", rob_rf_val, 32'h11);
    checkOutput("t1_head0", 32'(rob_head_id), 32'd1);
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd2, 32'h33, 0); tick();
    checkOutput("t1_rd1", 32'(rob_rf_rd), 32'd6);
    checkOutput("t1_val1", rob_rf_val, 32'h22);
    checkOutput("t1_head1", 32'(rob_head_id), 32'd2);
    idle(); tick();
    checkOutput("t1_en2", 32'(rob_rf_enable), 32'd1);
    checkOutput("t1_rd2", 32'(rob_rf_rd), 32'd7);
    checkOutput("t1_val2", rob_rf_val, 32'h33);
    checkOutput("t1_head2", 32'(rob_head_id), 32'd3);
    tick();
    checkOutput("t1_en_off", 32'(rob_rf_enable), 32'd0);

    // Fill, blocked ninth allocation, commit frees a slot, wrap to id 0
    doReset();
    stall = 1'b1;
    applyStimulus(1, 2'd0, 5'd1, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    checkOutput("t2_stall_tail", 32'(rob_tail_id), 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 2'd0, 5'(i + 1), 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    end
    checkOutput("t2_full", 32'(rob_full), 32'd1);
    checkOutput("t2_tail_wrap", 32'(rob_tail_id), 32'd0);
    tick();
    checkOutput("t2_ninth_tail", 32'(rob_tail_id), 32'd0);
    applyStimulus(1, 2'd0, 5'd9, 0, 32'd0, 1, 3'd0, 32'hA0, 0); tick();
    applyStimulus(1, 2'd0, 5'd9, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    checkOutput("t2_not_full", 32'(rob_full), 32'd0);
    checkOutput("t2_commit_rd", 32'(rob_rf_rd), 32'd1);
    checkOutput("t2_tail_held", 32'(rob_tail_id), 32'd0);
    tick();
    checkOutput("t2_realloc_tail", 32'(rob_tail_id), 32'd1);
    checkOutput("t2_full_again", 32'(rob_full), 32'd1);

    // Out-of-order writeback, in-order commit
    doReset();
    applyStimulus(1, 2'd0, 5'd10, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd11, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd12, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd2, 32'h202, 0); tick();
    checkOutput("t3_wait2", 32'(rob_rf_enable), 32'd0);
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd1, 32'h201, 0); tick();
    checkOutput("t3_wait1", 32'(rob_rf_enable), 32'd0);
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd0, 32'h200, 0); tick();
    checkOutput("t3_wait0", 32'(rob_rf_enable), 32'd0);
    idle(); tick();
    checkOutput("t3_c0_rd", 32'(rob_rf_rd), 32'd10);
    checkOutput("t3_c0_val", rob_rf_val, 32'h200);
    tick();
    checkOutput("t3_c1_rd", 32'(rob_rf_rd), 32'd11);
    tick();
    checkOutput("t3_c2_rd", 32'(rob_rf_rd), 32'd12);
    checkOutput("t3_c2_en", 32'(rob_rf_enable), 32'd1);

    // Mispredicted branch at id 3 with two younger entries
    applyStimulus(1, 2'd2, 5'd0, 0, 32'h1000, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd20, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd21, 0, 32'd0, 1, 3'd4, 32'h44, 0); tick();
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd3, 32'd0, 1); tick();
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd5, 32'h55, 0); tick();
    checkOutput("t4_flush", 32'(flush), 32'd1);
    checkOutput("t4_flush_pc", flush_pc, 32'h1000);
    checkOutput("t4_no_rf", 32'(rob_rf_enable), 32'd0);
    checkOutput("t4_head", 32'(rob_head_id), 32'd0);
    checkOutput("t4_tail", 32'(rob_tail_id), 32'd0);
    applyStimulus(1, 2'd0, 5'd30, 0, 32'd0, 1, 3'd0, 32'h99, 0); tick();
    checkOutput("t4_flush_off", 32'(flush), 32'd0);
    checkOutput("t4_ignored_alloc", 32'(rob_tail_id), 32'd0);
    checkOutput("t4_no_rf_after", 32'(rob_rf_enable), 32'd0);
    idle(); tick();

    // Store at id 3, pulse held across rdy=0
    applyStimulus(1, 2'd0, 5'd1, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd2, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd0, 5'd3, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    applyStimulus(1, 2'd1, 5'd0, 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'(i), 32'(i + 16), 0); tick();
    end
    idle(); tick();
    checkOutput("t5_store", 32'(rob_store_commit), 32'd1);
    checkOutput("t5_store_id", 32'(rob_store_id), 32'd3);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_store_held", 32'(rob_store_commit), 32'd1);
    end
    rdy = 1'b1;
    tick();
    checkOutput("t5_store_off", 32'(rob_store_commit), 32'd0);

    // Query bypass on a live, not-yet-committable entry
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'd0, 5'(i + 1), 0, 32'd0, 0, 3'd0, 32'd0, 0); tick();
    end
    qry1_id = 3'd4; qry2_id = 3'd0;
    applyStimulus(0, 2'd0, 5'd0, 0, 32'd0, 1, 3'd4, 32'hABCD, 0);
    #1;
    checkOutput("t6_bypass_ready", 32'(qry1_ready), 32'd1);
    checkOutput("t6_bypass_val", qry1_val, 32'hABCD);
    checkOutput("t6_other_ready", 32'(qry2_ready), 32'd0);
    tick();
    idle();
    #1;
    checkOutput("t6_entry_ready", 32'(qry1_ready), 32'd1);
    checkOutput("t6_entry_val", qry1_val, 32'hABCD);
    checkOutput("t6_no_commit", 32'(rob_rf_enable), 32'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
